// File: rtl/mux_sel_pipe.sv
// mux_sel_pipe
//   N-channel, W-bit registered selector with a valid/ready handshake on
//   every port. It acts as the operand/partial-product mux in the multiplier
//   datapath. One output register stage gives full throughput when there is
//   no back-pressure.
//
//   Selection modes:
//     rr_en = 0 : fixed mode. Channel `sel` is granted (sel >= NCH grants nothing).
//     rr_en = 1 : round-robin mode. The first valid channel at or after ptr wins.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    NCH*WIDTH, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational)
//   sel        fixed-mode channel select
//   rr_en      1 = round-robin, 0 = fixed
//   out_data   registered selected data
//   out_valid  output register holds data
//   out_ready  downstream accepts
//   out_ch     channel index that out_data came from
module mux_sel_pipe #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  localparam int SELW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [SELW-1:0]      sel,
  input  logic                 rr_en,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_ch
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  // NCH expressed one bit wider than sel, so that sel >= NCH can be
  // detected when NCH is not a power of two.
  localparam logic [SELW:0] NCH_W = (SELW+1)'(NCH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic [NCH-1:0]   grant;
  logic [SELW-1:0]  g_idx;
  logic             g_any;
  logic [WIDTH-1:0] g_data;
  logic             can_load;
  logic             accept;

  // Grant selection. Round-robin scans ptr, ptr+1, ... with a wrap.
  // Because ptr is always < NCH, a single subtraction is enough to wrap.
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    g_idx = '0;
    g_any = 1'b0;
    if (rr_en) begin
      for (int k = 0; k < NCH; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= NCH) idx = idx - NCH;
        if (!g_any && in_valid[idx]) begin
          g_any = 1'b1;
          g_idx = SELW'(idx);
        end
      end
    end else if ({1'b0, sel} < NCH_W) begin
      g_any = 1'b1;
      g_idx = sel;
    end
    if (g_any) grant[g_idx] = 1'b1;
  end

  // The grant is one-hot, so an AND-OR mux is sufficient.
  always_comb begin
    g_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant[i]) g_data = g_data | in_data[i*WIDTH +: WIDTH];
    end
  end

  assign can_load = (state_q == EMPTY) | out_ready;
  // While reset is asserted no channel is offered a ready.
  assign in_ready = grant & {NCH{can_load & rst_n}};
  assign accept   = |(in_valid & in_ready);

  // Next-state and output-register logic.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    ptr_d      = ptr_q;
    if (accept) begin
      state_d    = FULL;
      out_data_d = g_data;
      out_ch_d   = g_idx;
      if (rr_en) begin
        ptr_d = (g_idx == SELW'(NCH - 1)) ? '0 : g_idx + 1'b1;
      end
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      out_data_q <= '0;
      out_ch_q   <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
      ptr_q      <= ptr_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_sel_pipe.sv
// tb_mux_sel_pipe
//   This bench runs the default 4x4 instance against a queue-free behavioural
//   model of the selector (expected output word, output channel, validity and
//   rr pointer). It then runs directed scenarios and a randomized run. A second
//   instance with NCH=3 covers the out-of-range select case.
module tb_mux_sel_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_data = '0;
  logic [3:0]  in_valid = '0;
  logic [3:0]  in_ready;
  logic [1:0]  sel = '0;
  logic        rr_en = 1'b0;
  logic [3:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  out_ch;

  logic [11:0] in_data3 = '0;
  logic [2:0]  in_valid3 = '0;
  logic [2:0]  in_ready3;
  logic [1:0]  sel3 = '0;
  logic [3:0]  out_data3;
  logic        out_valid3;
  logic [1:0]  out_ch3;

  int n_total = 0;
  int n_bad   = 0;

  // Model state
  bit      m_valid = 0;
  int      m_data  = 0;
  int      m_ch    = 0;
  int      m_ptr   = 0;

  always #5 clk = ~clk;

  mux_sel_pipe #(.WIDTH(4), .NCH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .rr_en(rr_en), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
  );

  mux_sel_pipe #(.WIDTH(4), .NCH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .sel(sel3), .rr_en(1'b0), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(1'b1), .out_ch(out_ch3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Channel the rules grant this cycle, or -1 if none.
  function automatic int model_grant();
    if (rr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (in_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
      end
      return -1;
    end
    return int'(sel);
  endfunction

  // One clock cycle. Inputs are already driven at posedge+1. The bench
  // checks the ready, advances the model across the edge, then checks the
  // outputs.
  task automatic step(input string tag);
    int g;
    logic [3:0] exp_rdy;
    bit acc;
    #1;
    g = model_grant();
    exp_rdy = '0;
    if (g >= 0 && (!m_valid || out_ready) && rst_n) exp_rdy[g] = 1'b1;
    acc = (g >= 0) && exp_rdy[g] && in_valid[g];
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (acc) begin
      m_valid = 1;
      m_data  = int'((in_data >> (4 * g)) & 16'hF);
      m_ch    = g;
      if (rr_en) m_ptr = (g + 1) % 4;
    end else if (out_ready) begin
      m_valid = 0;
    end
    #1;
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk({tag, "_out_data"}, 32'(out_data), 32'(m_data));
      chk({tag, "_out_ch"}, 32'(out_ch), 32'(m_ch));
    end
    $display("[%0t] %s rr=%0b sel=%0d vld=%b rdy=%b acc=%0b -> ov=%0b od=%h oc=%0d",
             $time, tag, rr_en, sel, in_valid, in_ready, acc, out_valid, out_data, out_ch);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 4'hF;
    in_data  = 16'hFFFF;
    #2;
    m_valid = 0; m_ptr = 0;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data",  32'(out_data), 0);
    chk("rst_out_ch",    32'(out_ch), 0);
    chk("rst_in_ready",  32'(in_ready), 0);
    @(posedge clk); #1;
    rst_n    = 1'b1;
    in_valid = '0;
  endtask

  initial begin
    #3;
    // 1: reset
    do_reset();

    // 2: fixed mode, sel=2, ch2=A
    rr_en = 0; sel = 2; out_ready = 1;
    in_valid = 4'b0100; in_data = 16'h0A00;
    step("t2");
    chk("t2_data", 32'(out_data), 32'hA);
    chk("t2_ch",   32'(out_ch), 2);
    in_valid = '0;
    step("t2_drain");

    // 3: round-robin fairness from ptr=0
    do_reset();
    rr_en = 1; out_ready = 1; in_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      in_data = 16'($urandom);
      step("t3");
      chk("t3_seq", 32'(out_ch), 32'(i % 4));
    end

    // 4: skip. Accept ch1 first so that ptr becomes 2; then ch1 and ch3 alternate from ch3.
    in_valid = 4'b0010;
    step("t4_prep");
    in_valid = 4'b1010;
    step("t4a"); chk("t4_first",  32'(out_ch), 3);
    step("t4b"); chk("t4_second", 32'(out_ch), 1);
    step("t4c"); chk("t4_third",  32'(out_ch), 3);

    // 5: back-pressure hold, then a same-cycle reload
    rr_en = 0; sel = 0; in_valid = 4'b0001; in_data = 16'h0005;
    step("t5_load");
    out_ready = 0; in_valid = 4'hF;
    for (int i = 0; i < 3; i++) begin
      in_data = 16'($urandom) | 16'h0010;
      step("t5_hold");
      chk("t5_hold_data", 32'(out_data), 32'h5);
      chk("t5_hold_rdy",  32'(in_ready), 0);
    end
    out_ready = 1; sel = 1; in_data = 16'h00C0;
    #1 chk("t5_reload_rdy", 32'(in_ready), 32'b0010);
    step("t5_reload");
    chk("t5_reload_data", 32'(out_data), 32'hC);

    // 6a: NCH=3 instance, sel=3 grants nothing; sel=1 works
    sel3 = 3; in_valid3 = 3'b111; in_data3 = 12'h321;
    #1 chk("t6_sel3_rdy", 32'(in_ready3), 0);
    @(posedge clk); #1;
    chk("t6_sel3_ov", 32'(out_valid3), 0);
    sel3 = 1;
    #1 chk("t6_sel1_rdy", 32'(in_ready3), 32'b010);
    @(posedge clk); #1;
    chk("t6_sel1_ov",   32'(out_valid3), 1);
    chk("t6_sel1_data", 32'(out_data3), 32'h2);
    chk("t6_sel1_ch",   32'(out_ch3), 1);
    in_valid3 = '0;

    // 6b: reset pulse while FULL clears the output before the next edge
    sel = 2; in_valid = 4'b0100; in_data = 16'h0900; out_ready = 0;
    step("t6_fill");
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_ov", 32'(out_valid), 0);
    chk("t6_async_od", 32'(out_data), 0);
    m_valid = 0; m_ptr = 0;
    @(posedge clk); #1 rst_n = 1'b1;

    // Randomized run against the model
    for (int i = 0; i < 400; i++) begin
      in_data   = 16'($urandom);
      in_valid  = 4'($urandom);
      sel       = 2'($urandom);
      rr_en     = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 3) != 0);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
